delta_ram_reader: RTL and testbench

//  Read-side controller for the delta SRAM wrapper (addr_r/read_en port, 1-cycle read latency).

---
 rtl/delta_ram_reader_pkg.sv | 13 +
 rtl/delta_ram_reader_skid_fifo.sv | 62 ++++++
 rtl/delta_ram_reader.sv | 121 ++++++++++++
 tb/tb_delta_ram_reader.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/delta_ram_reader_pkg.sv
// Shared types and default widths for the delta SRAM read-side controller.
package delta_ram_reader_pkg;

  localparam int DEF_SRAM_DEPTH_BIT = 6;
  localparam int DEF_SRAM_WIDTH     = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/delta_ram_reader_skid_fifo.sv
// Two-entry register FIFO that holds SRAM read data until the stream consumer accepts it.
module delta_ram_reader_skid_fifo
  import delta_ram_reader_pkg::*;
#(
  parameter int WIDTH = DEF_SRAM_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic [1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (clear) begin
      entry0_q <= '0;
      entry1_q <= '0;
      cnt_q    <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) entry0_d = push_data;
        else               entry1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        entry0_d = entry1_q;
        cnt_d    = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          entry0_d = push_data;
        end else begin
          entry0_d = entry1_q;
          entry1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  assign cnt  = cnt_q;
  assign head = entry0_q;

endmodule

// File: rtl/delta_ram_reader.sv
// Burst read controller: issues sequential wrapped SRAM reads and returns the words
// as a valid/ready stream, throttling issue so the 2-entry FIFO never overflows.
module delta_ram_reader
  import delta_ram_reader_pkg::*;
#(
  parameter int SRAM_DEPTH_BIT = DEF_SRAM_DEPTH_BIT,
  parameter int SRAM_WIDTH     = DEF_SRAM_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SRAM_DEPTH_BIT-1:0] base_addr,
  input  logic [SRAM_DEPTH_BIT:0]   len,
  output logic                      busy,
  output logic                      done,
  output logic                      ram_read_en,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
  input  logic [SRAM_WIDTH-1:0]     ram_data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SRAM_WIDTH-1:0]     out_data,
  output logic                      out_last
);

  localparam int LEN_W = SRAM_DEPTH_BIT + 1;
  localparam logic [LEN_W-1:0]          LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [SRAM_DEPTH_BIT-1:0] ADDR_ONE = {{(SRAM_DEPTH_BIT-1){1'b0}}, 1'b1};

  state_e                    state_q, state_d;
  logic [SRAM_DEPTH_BIT-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]          rd_left_q, rd_left_d;
  logic [LEN_W-1:0]          pop_left_q, pop_left_d;
  logic                      inflight_q;
  logic                      done_q, done_d;

  logic [1:0]                fifo_cnt;
  logic [SRAM_WIDTH-1:0]     fifo_head;
  logic                      pop;
  logic [2:0]                credit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      rd_left_q  <= '0;
      pop_left_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_left_q  <= rd_left_d;
      pop_left_q <= pop_left_d;
      inflight_q <= ram_read_en;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_left_d  = rd_left_q;
    pop_left_d = pop_left_q;
    done_d     = 1'b0;
    if (ram_read_en) begin
      rd_addr_d = rd_addr_q + ADDR_ONE;
      rd_left_d = rd_left_q - LEN_ONE;
    end
    if (pop) pop_left_d = pop_left_q - LEN_ONE;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_READ;
            rd_addr_d  = base_addr;
            rd_left_d  = len;
            pop_left_d = len;
          end
        end
      end
      ST_READ: begin
        if (ram_read_en && rd_left_q == LEN_ONE) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy after this cycle's pop, counting the word still in the SRAM pipeline.
  always_comb begin
    out_valid   = fifo_cnt != 2'd0;
    pop         = out_valid && out_ready;
    credit      = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    ram_read_en = (state_q == ST_READ) && (rd_left_q != '0) && (credit < 3'd2);
    ram_addr_r  = rd_addr_q;
    out_data    = fifo_head;
    out_last    = out_valid && (pop_left_q == LEN_ONE);
    busy        = state_q != ST_IDLE;
    done        = done_q;
  end

  delta_ram_reader_skid_fifo #(
    .WIDTH(SRAM_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .clear    (rst),
    .push     (inflight_q),
    .pop      (pop),
    .push_data(ram_data_out),
    .cnt      (fifo_cnt),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_delta_ram_reader.sv
// Directed bench for delta_ram_reader against a 1-cycle-latency SRAM model holding mem[i]=i.
module tb_delta_ram_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  len;
  logic        busy;
  logic        done;
  logic        ram_read_en;
  logic [5:0]  ram_addr_r;
  logic [27:0] ram_data_out;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_data;
  logic        out_last;

  logic [27:0] mem [64];
  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_read_en) ram_data_out <= mem[ram_addr_r];
  end

  delta_ram_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .ram_read_en (ram_read_en),
    .ram_addr_r  (ram_addr_r),
    .ram_data_out(ram_data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full-throughput burst: issue in cycles 1..n, data in 3..n+2, done in n+3.
  task automatic run_full_burst(input int base, input int n);
    start = 1'b1; base_addr = 6'(base); len = 7'(n); out_ready = 1'b1;
    tick();
    start = 1'b0;
    #1;
    for (int c = 1; c <= n + 3; c++) begin
      if (c > 1) begin tick(); #1; end
      if (c <= n) begin
        check("burst_rd_en", 32'(ram_read_en), 32'd1);
        check("burst_rd_addr", 32'(ram_addr_r), 32'((base + c - 1) & 63));
      end else begin
        check("burst_rd_en_off", 32'(ram_read_en), 32'd0);
      end
      if (c >= 3 && c <= n + 2) begin
        check("burst_valid", 32'(out_valid), 32'd1);
        check("burst_data", 32'(out_data), 32'((base + c - 3) & 63));
        check("burst_last", 32'(out_last), 32'(c == n + 2));
      end else begin
        check("burst_valid_off", 32'(out_valid), 32'd0);
      end
      check("burst_done", 32'(done), 32'(c == n + 3));
      check("burst_busy", 32'(busy), 32'(c <= n + 2));
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 28'(i);
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    tick(); tick();
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(ram_read_en), 32'd0);
    check("rst_addr", 32'(ram_addr_r), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] burst base=5 len=4");
    run_full_burst(5, 4);

    $display("[TB] burst base=62 len=4 with wrap");
    run_full_burst(62, 4);

    $display("[TB] backpressure base=0 len=4");
    start = 1'b1; base_addr = 6'd0; len = 7'd4; out_ready = 1'b1;
    tick(); start = 1'b0; #1;
    check("bp_c1_en", 32'(ram_read_en), 32'd1);
    check("bp_c1_addr", 32'(ram_addr_r), 32'd0);
    tick(); #1;
    check("bp_c2_en", 32'(ram_read_en), 32'd1);
    check("bp_c2_addr", 32'(ram_addr_r), 32'd1);
    for (int c = 3; c <= 8; c++) begin
      tick(); out_ready = 1'b0; #1;
      check("bp_stall_en", 32'(ram_read_en), 32'd0);
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_data", 32'(out_data), 32'd0);
      check("bp_stall_last", 32'(out_last), 32'd0);
    end
    tick(); out_ready = 1'b1; #1;
    check("bp_c9_data", 32'(out_data), 32'd0);
    check("bp_c9_en", 32'(ram_read_en), 32'd1);
    check("bp_c9_addr", 32'(ram_addr_r), 32'd2);
    tick(); #1;
    check("bp_c10_data", 32'(out_data), 32'd1);
    check("bp_c10_en", 32'(ram_read_en), 32'd1);
    check("bp_c10_addr", 32'(ram_addr_r), 32'd3);
    tick(); #1;
    check("bp_c11_data", 32'(out_data), 32'd2);
    check("bp_c11_en", 32'(ram_read_en), 32'd0);
    check("bp_c11_last", 32'(out_last), 32'd0);
    tick(); #1;
    check("bp_c12_data", 32'(out_data), 32'd3);
    check("bp_c12_last", 32'(out_last), 32'd1);
    check("bp_c12_done", 32'(done), 32'd0);
    tick(); #1;
    check("bp_c13_done", 32'(done), 32'd1);
    check("bp_c13_valid", 32'(out_valid), 32'd0);
    tick();

    $display("[TB] zero-length burst");
    start = 1'b1; base_addr = 6'd9; len = 7'd0;
    tick(); start = 1'b0; #1;
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_rd_en", 32'(ram_read_en), 32'd0);
    check("len0_valid", 32'(out_valid), 32'd0);
    tick(); #1;
    check("len0_done_clear", 32'(done), 32'd0);
    check("len0_rd_en2", 32'(ram_read_en), 32'd0);
    check("len0_valid2", 32'(out_valid), 32'd0);

    $display("[TB] reset mid-burst");
    start = 1'b1; base_addr = 6'd10; len = 7'd8; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); #1;
    check("abort_w0", 32'(out_data), 32'd10);
    tick(); #1;
    check("abort_w1", 32'(out_data), 32'd11);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rd_en", 32'(ram_read_en), 32'd0);
    tick(); #1;
    check("abort_done2", 32'(done), 32'd0);
    check("abort_busy2", 32'(busy), 32'd0);
    run_full_burst(0, 2);

    $display("[TB] full-RAM burst with random ready");
    begin
      int delivered = 0;
      int cyc = 0;
      bit saw_done = 1'b0;
      start = 1'b1; base_addr = 6'd17; len = 7'd64;
      tick();
      while (!saw_done && cyc < 3000) begin
        out_ready = 1'($urandom_range(0, 1));
        start = (delivered < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
        base_addr = 6'd40; len = 7'd3;
        #1;
        if (done) saw_done = 1'b1;
        if (out_valid && out_ready) begin
          check("full_data", 32'(out_data), 32'((17 + delivered) & 63));
          check("full_last", 32'(out_last), 32'(delivered == 63));
          delivered++;
        end
        tick();
        cyc++;
      end
      start = 1'b0;
      check("full_done_seen", 32'(saw_done), 32'd1);
      check("full_count", 32'(delivered), 32'd64);
      #1;
      check("full_idle_busy", 32'(busy), 32'd0);
      tick(); #1;
      check("full_idle_busy2", 32'(busy), 32'd0);
      check("full_idle_valid", 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
